music_sequencer: RTL and testbench

//   Drives the 8-bit fullnote input of the speaker tone generator. Walks a song table
//   in an external synchronous ROM; each entry is one note plus its duration in tempo ticks.

---
 rtl/music_sequencer_if.sv | 43 ++++
 rtl/music_sequencer.sv | 172 +++++++++++++++++
 tb/tb_music_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/music_sequencer_if.sv
// Song ROM bus plus the control and tone-generator signals of the music sequencer.
// The master side is the sequencer; the slave side is the surrounding system
// (control logic, song ROM and tone generator).
interface music_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  // Control
  logic              start;
  logic              stop;
  logic              loop_en;
  // Song ROM
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  // Tone generator and status
  logic [7:0]        fullnote;
  logic              note_strobe;
  logic              busy;
  logic              done;

  modport master (
    input  start,
    input  stop,
    input  loop_en,
    input  rom_data,
    output rom_addr,
    output fullnote,
    output note_strobe,
    output busy,
    output done
  );

  modport slave (
    output start,
    output stop,
    output loop_en,
    output rom_data,
    input  rom_addr,
    input  fullnote,
    input  note_strobe,
    input  busy,
    input  done
  );
endinterface

// File: rtl/music_sequencer.sv
// Music sequencer: walks a song table in a synchronous ROM and drives the tone
// generator's fullnote input. Each ROM word is {fullnote, duration in ticks};
// a duration of 0 marks the end of the song. Every note is followed by
// GAP_TICKS of silence so that repeated notes stay distinct.
module music_sequencer #(
  parameter int unsigned TICK_DIV  = 1562500,
  parameter int unsigned GAP_TICKS = 1,
  parameter int unsigned ADDR_W    = 8
) (
  input logic               clk,
  input logic               rst_n,
  music_sequencer_if.master bus
);

  // Prescaler counts 0..TICK_DIV-1; keep it at least one bit wide for TICK_DIV=1.
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Tick counter holds either a note duration (8 bits) or GAP_TICKS.
  localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);
  localparam int unsigned CNT_W = (GAP_W > 8) ? GAP_W : 8;

  // Highest playable fullnote: 6 octaves of 12 semitones; anything above is a rest.
  localparam logic [7:0] MaxNote = 8'd71;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StLatch = 3'd2;
  localparam logic [2:0] StPlay  = 3'd3;
  localparam logic [2:0] StGap   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        note_q, note_d;
  logic              strobe_q, strobe_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0]  rem_q, rem_d;

  logic [7:0]        rom_note;
  logic [7:0]        rom_dur;
  logic              tick;

  assign rom_note = bus.rom_data[15:8];
  assign rom_dur  = bus.rom_data[7:0];
  assign tick     = (pre_q == PRE_W'(TICK_DIV - 1));

  // Next-state logic: stop beats start, start beats everything else.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    note_d   = note_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    pre_d    = pre_q;
    rem_d    = rem_q;

    if (bus.stop) begin
      state_d = StIdle;
      addr_d  = '0;
      note_d  = '0;
    end else if (bus.start) begin
      // Restart from the top of the song, silencing any note in progress.
      state_d = StFetch;
      addr_d  = '0;
      note_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          addr_d = '0;
        end

        StFetch: begin
          // rom_addr is presented this cycle; data arrives in LATCH.
          state_d = StLatch;
        end

        StLatch: begin
          if (rom_dur == 8'd0) begin
            // End marker. An empty song never loops, so it cannot spin forever.
            if (bus.loop_en && (addr_q != '0)) begin
              addr_d  = '0;
              state_d = StFetch;
            end else begin
              done_d  = 1'b1;
              note_d  = '0;
              addr_d  = '0;
              state_d = StIdle;
            end
          end else begin
            note_d   = (rom_note > MaxNote) ? 8'd0 : rom_note;
            strobe_d = 1'b1;
            rem_d    = CNT_W'(rom_dur);
            pre_d    = '0;
            state_d  = StPlay;
          end
        end

        StPlay: begin
          if (tick) begin
            pre_d = '0;
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              if (GAP_TICKS > 0) begin
                note_d  = '0;
                rem_d   = CNT_W'(GAP_TICKS);
                state_d = StGap;
              end else begin
                // Legato: note stays on through the FETCH/LATCH overhead.
                addr_d  = addr_q + ADDR_W'(1);
                state_d = StFetch;
              end
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end

        StGap: begin
          if (tick) begin
            pre_d = '0;
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              // Address wraps mod 2^ADDR_W; only the end marker ends the song.
              addr_d  = addr_q + ADDR_W'(1);
              state_d = StFetch;
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end

        default: begin
          state_d = StIdle;
          addr_d  = '0;
          note_d  = '0;
        end
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      note_q   <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      pre_q    <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      note_q   <= note_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      pre_q    <= pre_d;
      rem_q    <= rem_d;
    end
  end

  assign bus.rom_addr    = addr_q;
  assign bus.fullnote    = note_q;
  assign bus.note_strobe = strobe_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer. Two instances with TICK_DIV=4: one with a
// one-tick gap after each note, one legato (GAP_TICKS=0). Each has its own ROM.
// Cycle n is the interval after the n-th rising edge following the start pulse;
// inputs are driven and outputs sampled 1 ns after a rising edge.
module tb_music_sequencer;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errors;

  logic [15:0] rom_a [256];
  logic [15:0] rom_b [256];

  music_sequencer_if #(.ADDR_W(8)) bus_a ();
  music_sequencer_if #(.ADDR_W(8)) bus_b ();

  music_sequencer #(
    .TICK_DIV  (4),
    .GAP_TICKS (1),
    .ADDR_W    (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  music_sequencer #(
    .TICK_DIV  (4),
    .GAP_TICKS (0),
    .ADDR_W    (8)
  ) u_legato (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROMs: data valid one cycle after the address.
  always @(posedge clk) begin
    bus_a.rom_data <= rom_a[bus_a.rom_addr];
    bus_b.rom_data <= rom_b[bus_b.rom_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns in cycle 1.
  task automatic start_a();
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
  endtask

  task automatic start_b();
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
  endtask

  task automatic stop_a();
    bus_a.stop = 1'b1;
    step();
    bus_a.stop = 1'b0;
  endtask

  task automatic load_song1();
    for (int i = 0; i < 256; i++) rom_a[i] = 16'h0000;
    rom_a[0] = 16'h0903;
    rom_a[1] = 16'h1502;
    rom_a[2] = 16'h0000;
  endtask

  initial begin
    logic [7:0] exp_note;
    logic [7:0] prev_addr;
    int strobes;
    int dones;
    int wrapped;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.loop_en = 1'b0;
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.loop_en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = 16'h0000;
      rom_b[i] = 16'h0000;
    end

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr",   32'(bus_a.rom_addr), 0);
    check("rst_note",   32'(bus_a.fullnote), 0);
    check("rst_strobe", 32'(bus_a.note_strobe), 0);
    check("rst_busy",   32'(bus_a.busy), 0);
    check("rst_done",   32'(bus_a.done), 0);
    rst_n = 1'b1;
    step();

    // Test 1: two notes with gaps, then done
    load_song1();
    bus_a.loop_en = 1'b0;
    start_a();
    strobes = 0;
    dones = 0;
    check("t1_addr0", 32'(bus_a.rom_addr), 0);
    check("t1_busy1", 32'(bus_a.busy), 1);
    for (int c = 1; c <= 37; c++) begin
      exp_note = (c >= 3 && c <= 14) ? 8'h09 : (c >= 21 && c <= 28) ? 8'h15 : 8'h00;
      check($sformatf("t1_note_c%0d", c), 32'(bus_a.fullnote), 32'(exp_note));
      if (bus_a.note_strobe) strobes++;
      if (bus_a.done) begin
        dones++;
        check("t1_done_cycle", 32'(c), 35);
      end
      if (c == 19) check("t1_addr1", 32'(bus_a.rom_addr), 1);
      if (c == 33) check("t1_addr2", 32'(bus_a.rom_addr), 2);
      if (c == 34) check("t1_busy_c34", 32'(bus_a.busy), 1);
      if (c == 35) check("t1_busy_c35", 32'(bus_a.busy), 0);
      step();
    end
    check("t1_strobes", 32'(strobes), 2);
    check("t1_dones", 32'(dones), 1);

    // Test 2: looping, then stop
    bus_a.loop_en = 1'b1;
    start_a();
    dones = 0;
    for (int c = 1; c <= 40; c++) begin
      exp_note = (c >= 3 && c <= 14) ? 8'h09 : (c >= 21 && c <= 28) ? 8'h15 :
                 (c >= 37) ? 8'h09 : 8'h00;
      if (c >= 27) check($sformatf("t2_note_c%0d", c), 32'(bus_a.fullnote), 32'(exp_note));
      if (c == 35) check("t2_addr_loop", 32'(bus_a.rom_addr), 0);
      if (c == 37) check("t2_strobe", 32'(bus_a.note_strobe), 1);
      if (bus_a.done) dones++;
      step();
    end
    check("t2_dones", 32'(dones), 0);
    check("t2_busy_before_stop", 32'(bus_a.busy), 1);
    stop_a();
    check("t2_stop_note", 32'(bus_a.fullnote), 0);
    check("t2_stop_busy", 32'(bus_a.busy), 0);
    check("t2_stop_done", 32'(bus_a.done), 0);
    bus_a.loop_en = 1'b0;
    step();

    // Test 3: empty song with loop_en=1 must end, not spin
    rom_a[0] = 16'h0000;
    bus_a.loop_en = 1'b1;
    start_a();
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("t3_done_c%0d", c), 32'(bus_a.done), (c == 3) ? 1 : 0);
      check($sformatf("t3_busy_c%0d", c), 32'(bus_a.busy), (c < 3) ? 1 : 0);
      step();
    end
    bus_a.loop_en = 1'b0;

    // Test 4: out-of-range note plays as a rest but still strobes
    rom_a[0] = 16'h4802;
    rom_a[1] = 16'h0000;
    start_a();
    for (int c = 1; c <= 18; c++) begin
      check($sformatf("t4_note_c%0d", c), 32'(bus_a.fullnote), 0);
      check($sformatf("t4_strobe_c%0d", c), 32'(bus_a.note_strobe), (c == 3) ? 1 : 0);
      check($sformatf("t4_done_c%0d", c), 32'(bus_a.done), (c == 17) ? 1 : 0);
      step();
    end

    // Test 5: legato instance holds the note through the fetch overhead
    rom_b[0] = 16'h0C01;
    rom_b[1] = 16'h0C01;
    rom_b[2] = 16'h0000;
    start_b();
    strobes = 0;
    for (int c = 1; c <= 16; c++) begin
      exp_note = (c >= 3 && c <= 14) ? 8'h0C : 8'h00;
      check($sformatf("t5_note_c%0d", c), 32'(bus_b.fullnote), 32'(exp_note));
      check($sformatf("t5_done_c%0d", c), 32'(bus_b.done), (c == 15) ? 1 : 0);
      if (bus_b.note_strobe) strobes++;
      step();
    end
    check("t5_strobes", 32'(strobes), 2);
    start_b();
    step();
    step();
    check("t5_replay_note", 32'(bus_b.fullnote), 32'h0C);
    bus_b.start = 1'b1;
    bus_b.stop  = 1'b1;
    step();
    bus_b.start = 1'b0;
    bus_b.stop  = 1'b0;
    check("t5_stopstart_busy", 32'(bus_b.busy), 0);
    check("t5_stopstart_note", 32'(bus_b.fullnote), 0);
    step();
    check("t5_stays_idle", 32'(bus_b.busy), 0);

    // Start while busy restarts at address 0 with silence
    load_song1();
    start_a();
    repeat (5) step();
    check("rs_note_before", 32'(bus_a.fullnote), 32'h09);
    start_a();
    check("rs_note_silent", 32'(bus_a.fullnote), 0);
    check("rs_addr", 32'(bus_a.rom_addr), 0);
    check("rs_busy", 32'(bus_a.busy), 1);
    step();
    step();
    check("rs_note_again", 32'(bus_a.fullnote), 32'h09);
    check("rs_strobe", 32'(bus_a.note_strobe), 1);
    stop_a();

    // Address wraps past 255 without a done pulse
    for (int i = 0; i < 256; i++) rom_a[i] = 16'h0501;
    start_a();
    prev_addr = 8'd0;
    wrapped = 0;
    dones = 0;
    for (int k = 0; k < 2700; k++) begin
      if (bus_a.done) dones++;
      if (prev_addr == 8'd255 && bus_a.rom_addr == 8'd0) wrapped = 1;
      prev_addr = bus_a.rom_addr;
      step();
    end
    check("wrap_seen", 32'(wrapped), 1);
    check("wrap_dones", 32'(dones), 0);
    check("wrap_busy", 32'(bus_a.busy), 1);
    stop_a();

    // Test 6: asynchronous reset in the middle of a note
    load_song1();
    start_a();
    repeat (4) step();
    check("t6_note_pre", 32'(bus_a.fullnote), 32'h09);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_note", 32'(bus_a.fullnote), 0);
    check("t6_rst_busy", 32'(bus_a.busy), 0);
    check("t6_rst_addr", 32'(bus_a.rom_addr), 0);
    step();
    rst_n = 1'b1;
    step();
    start_a();
    check("t6_addr0", 32'(bus_a.rom_addr), 0);
    step();
    step();
    check("t6_note", 32'(bus_a.fullnote), 32'h09);
    check("t6_strobe", 32'(bus_a.note_strobe), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
